// File: rtl/sdf_stage_ctrl.sv
// Sequencing controller for one R2^2 SDF FFT stage pair of span S.
// Drives butterfly mux selects, output valid/index and the twiddle address.
module sdf_stage_ctrl #(
  parameter int N      = 64,
  parameter int S      = 64,
  parameter int BF_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_in,
  output logic                 bf1_sel,
  output logic                 bf2_sel,
  output logic                 rot_j,
  output logic                 enable_out,
  output logic [$clog2(N)-1:0] out_cnt,
  output logic [$clog2(S)-1:0] tw_addr,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 err
);
  localparam int LOGN = $clog2(N);
  localparam int LOGS = $clog2(S);
  localparam int LAT  = S / 2 + BF_LAT;
  localparam int DW   = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [LOGN-1:0] in_cnt_q, in_cnt_d, in_cur;
  logic [LOGN-1:0] out_cnt_q, out_cnt_d;
  logic [LAT-1:0]  vsr_q, vsr_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            err_q;
  logic            abort, acc;
  logic [LOGS-1:0] m, rx;
  logic [1:0]      q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      vsr_q     <= '0;
      drain_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      vsr_q     <= vsr_d;
      drain_q   <= drain_d;
      err_q     <= abort;
    end
  end

  // A frame starting during DRAIN takes beat 0 in that same cycle
  assign in_cur = (state_q == DRAIN && enable_in) ? '0 : in_cnt_q;

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_in) state_d = RUN;
      end
      RUN: begin
        if (!enable_in) begin
          if (in_cnt_q == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
            abort   = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (enable_in) state_d = RUN;
        else if (drain_q == DW'(LAT - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    acc      = enable_in & ~abort;
    in_cnt_d = (state_d == IDLE) ? '0 : in_cur + LOGN'(1);
    vsr_d    = abort ? '0 : {vsr_q[LAT-2:0], acc};

    out_cnt_d = out_cnt_q;
    if (abort) out_cnt_d = '0;
    else if (vsr_q[LAT-1]) out_cnt_d = out_cnt_q + LOGN'(1);

    // The boundary RUN cycle is the first of the LAT drain cycles
    drain_d = '0;
    if (state_d == DRAIN) begin
      if (state_q == DRAIN) drain_d = drain_q + DW'(1);
      else drain_d = DW'(1);
    end
  end

  always_comb begin
    enable_out = vsr_q[LAT-1];
    bf1_sel    = in_cur[LOGS-1];
    bf2_sel    = in_cur[LOGS-2];
    rot_j      = in_cur[LOGS-1] & ~in_cur[LOGS-2];
    out_cnt    = out_cnt_q;
    frame_done = enable_out & (out_cnt_q == LOGN'(N - 1));
    busy       = (state_q != IDLE) | (|vsr_q);
    err        = err_q;

    m  = out_cnt_q[LOGS-1:0];
    q  = m[LOGS-1 -: 2];
    rx = {2'b00, m[LOGS-3:0]};
    tw_addr = '0;
    if (enable_out) begin
      case (q)
        2'd0: tw_addr = '0;
        2'd1: tw_addr = rx << 1;
        2'd2: tw_addr = rx;
        2'd3: tw_addr = rx + (rx << 1);
      endcase
    end
  end
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: directed test-plan steps plus random enable
// bursts on an N=S=8 and an N=S=16 instance, checked against a frame model.
module tb_sdf_stage_ctrl;
  localparam int MAXC = 2048;
  localparam int EO = 19;
  localparam int FD = 2;
  localparam int BZ = 1;
  localparam int ER = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       en8, en16;
  logic       b1_8, b2_8, rj_8, eo_8, fd_8, bz_8, er_8;
  logic [2:0] oc_8, tw_8;
  logic       b1_16, b2_16, rj_16, eo_16, fd_16, bz_16, er_16;
  logic [3:0] oc_16, tw_16;

  always #5 clk = ~clk;

  sdf_stage_ctrl #(.N(8), .S(8), .BF_LAT(1)) u8 (
    .clk(clk), .rst(rst), .enable_in(en8),
    .bf1_sel(b1_8), .bf2_sel(b2_8), .rot_j(rj_8),
    .enable_out(eo_8), .out_cnt(oc_8), .tw_addr(tw_8),
    .frame_done(fd_8), .busy(bz_8), .err(er_8)
  );

  sdf_stage_ctrl #(.N(16), .S(16), .BF_LAT(1)) u16 (
    .clk(clk), .rst(rst), .enable_in(en16),
    .bf1_sel(b1_16), .bf2_sel(b2_16), .rot_j(rj_16),
    .enable_out(eo_16), .out_cnt(oc_16), .tw_addr(tw_16),
    .frame_done(fd_16), .busy(bz_16), .err(er_16)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int NN[2] = '{8, 16};
  int SS[2] = '{8, 16};
  int LT[2] = '{5, 9};
  int fq[4] = '{0, 2, 1, 3};
  int tw16[16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};

  // Model: a session is live from its first beat until LAT idle input
  // cycles after a frame boundary; outputs replay accepted beats LAT later.
  bit  act[2];
  int  gap[2];
  int  icnt[2];
  int  ocnt[2];
  bit  errp[2];
  int  kill[2] = '{-1, -1};
  bit  acc[2][MAXC];
  logic [22:0] ob[2];
  int  rem[2];
  int  gp[2];
  int  n3;

  function automatic logic [22:0] pk(
    input logic b1, input logic b2, input logic rj, input logic eo,
    input logic [7:0] oc, input logic [7:0] tw,
    input logic fd, input logic bz, input logic er);
    return {b1, b2, rj, eo, oc, tw, fd, bz, er};
  endfunction

  function automatic bit exp_en(input int i, input int t);
    int ts;
    ts = t - LT[i];
    return ts >= 0 && ts > kill[i] && acc[i][ts];
  endfunction

  function automatic logic [22:0] model_out(input int i, input bit e);
    int cur, oc, mm, qq, rr, tw;
    bit eo, b1, b2, bz;
    if (rst) return '0;
    cur = (act[i] && gap[i] > 0 && e) ? 0 : (act[i] ? icnt[i] : 0);
    b1 = ((cur / (SS[i] / 2)) % 2) == 1;
    b2 = ((cur / (SS[i] / 4)) % 2) == 1;
    eo = exp_en(i, cyc);
    oc = ocnt[i];
    mm = oc % SS[i];
    qq = mm / (SS[i] / 4);
    rr = mm % (SS[i] / 4);
    tw = eo ? rr * fq[qq] : 0;
    bz = act[i];
    for (int ts = cyc - LT[i]; ts < cyc; ts++)
      if (ts >= 0 && ts > kill[i] && acc[i][ts]) bz = 1'b1;
    return pk(b1, b2, b1 && !b2, eo, 8'(oc), 8'(tw),
              eo && (oc == NN[i] - 1), bz, errp[i]);
  endfunction

  task automatic upd(input int i, input bit e);
    bit run, drn, ab;
    int cur;
    ab = 1'b0;
    if (rst) begin
      act[i] = 0; gap[i] = 0; icnt[i] = 0; ocnt[i] = 0;
      errp[i] = 0; kill[i] = cyc; acc[i][cyc] = 0;
      return;
    end
    run = act[i] && gap[i] == 0;
    drn = act[i] && gap[i] > 0;
    cur = (drn && e) ? 0 : icnt[i];
    if (exp_en(i, cyc)) ocnt[i] = (ocnt[i] + 1) % NN[i];
    acc[i][cyc] = e;
    if (e) begin
      act[i] = 1; gap[i] = 0; icnt[i] = (cur + 1) % NN[i];
    end else if (run && icnt[i] == 0) begin
      gap[i] = 1; icnt[i] = 1;
    end else if (run) begin
      ab = 1; act[i] = 0; icnt[i] = 0; ocnt[i] = 0; kill[i] = cyc;
    end else if (drn) begin
      gap[i]++;
      if (gap[i] == LT[i]) begin
        act[i] = 0; gap[i] = 0; icnt[i] = 0;
      end else begin
        icnt[i] = (cur + 1) % NN[i];
      end
    end
    errp[i] = ab;
  endtask

  task automatic chk(input string tag, input logic [22:0] obs,
                     input logic [22:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic grab();
    ob[0] = pk(b1_8, b2_8, rj_8, eo_8, 8'(oc_8), 8'(tw_8), fd_8, bz_8, er_8);
    ob[1] = pk(b1_16, b2_16, rj_16, eo_16, 8'(oc_16), 8'(tw_16),
               fd_16, bz_16, er_16);
  endtask

  task automatic step(input logic e8, input logic e16);
    en8 = e8;
    en16 = e16;
    @(negedge clk);
    grab();
    chk($sformatf("cyc%0d_n8", cyc), ob[0], model_out(0, e8));
    chk($sformatf("cyc%0d_n16", cyc), ob[1], model_out(1, e16));
    @(posedge clk);
    upd(0, e8);
    upd(1, e16);
    cyc++;
    #1;
  endtask

  task automatic frame1(input string tg);
    for (int k = 0; k < 14; k++) begin
      step(k < 8, 1'b0);
      if (k < 8)
        chk({tg, "_sel"}, 23'(ob[0][22:20]), 23'({k[2], k[1], k[2] & ~k[1]}));
      chk({tg, "_eo"}, 23'(ob[0][EO]), 23'(k >= 5 && k <= 12));
      chk({tg, "_fd"}, 23'(ob[0][FD]), 23'(k == 12));
      chk({tg, "_busy"}, 23'(ob[0][BZ]), 23'(k >= 1 && k <= 12));
      if (k >= 5 && k <= 12)
        chk({tg, "_oc"}, 23'(ob[0][18:11]), 23'(k - 5));
    end
  endtask

  initial begin
    rst = 1'b1;
    en8 = 1'b0;
    en16 = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1);
    chk("reset_zero", ob[0], '0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);

    frame1("t1");
    step(1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      step(k < 16, 1'b0);
      chk("t2_eo", 23'(ob[0][EO]), 23'(k >= 5 && k <= 20));
      chk("t2_fd", 23'(ob[0][FD]), 23'(k == 12 || k == 20));
    end

    n3 = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, k < 16);
      if (ob[1][EO]) begin
        n3++;
        chk("t3_tw", 23'(ob[1][10:3]), 23'(tw16[int'(ob[1][18:11])]));
      end
    end
    chk("t3_count", 23'(n3), 23'd16);

    for (int k = 0; k < 15; k++) begin
      step(k < 4, 1'b0);
      chk("t4_eo", 23'(ob[0][EO]), '0);
      chk("t4_err", 23'(ob[0][ER]), 23'(k == 5));
      chk("t4_oc", 23'(ob[0][18:11]), '0);
      if (k == 5) chk("t4_busy", 23'(ob[0][BZ]), '0);
    end

    for (int k = 0; k < 31; k++) begin
      step(k < 8 || (k >= 10 && k < 18), 1'b0);
      chk("t5_eo", 23'(ob[0][EO]), 23'((k >= 5 && k <= 12) || (k >= 15 && k <= 22)));
      chk("t5_err", 23'(ob[0][ER]), '0);
      if (ob[0][EO])
        chk("t5_oc", 23'(ob[0][18:11]), 23'(k <= 12 ? k - 5 : k - 15));
      if (k >= 10 && k < 18)
        chk("t5_sel", 23'(ob[0][22:20]),
            23'({(k - 10) >= 4, ((k - 10) % 4) >= 2, (k - 10) == 4 || (k - 10) == 5}));
    end

    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    en8 = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    grab();
    chk("t6_rst_n8", ob[0], '0);
    chk("t6_rst_n16", ob[1], '0);
    @(posedge clk);
    upd(0, 1'b1);
    upd(1, 1'b0);
    cyc++;
    #1;
    step(1'b1, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    frame1("t6");
    step(1'b0, 1'b0);

    for (int c = 0; c < 600; c++) begin
      logic [1:0] e;
      rst = (c == 300 || c == 301);
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0 && gp[i] > 0) begin
          gp[i]--;
          e[i] = 1'b0;
        end else begin
          if (rem[i] == 0) begin
            rem[i] = ($urandom_range(0, 3) == 0) ?
                     int'($urandom_range(1, NN[i] - 1)) :
                     NN[i] * int'($urandom_range(1, 3));
            gp[i] = int'($urandom_range(0, 12));
          end
          rem[i]--;
          e[i] = 1'b1;
        end
      end
      step(e[0], e[1]);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
